// File: rtl/vdic_serial_alu.sv
// ---------------------------------------------------------------------------
// vdic_serial_alu
//   Serial-in / serial-out ALU. Requests arrive as 10-bit words (type, 8-bit
//   payload, even parity), MSB first. Up to two DATA words form operands A
//   and B. A CONTROL word carries the command and triggers the calculation.
//   The response is three words (STATUS, result high, result low), shifted
//   out back to back on dout with dout_valid high.
//
// Parameters
//   RSP_DELAY  cycles from sampling the CONTROL parity bit to the first
//              response bit (1..15)
//
// Ports
//   clk         clock, all state changes on posedge
//   rst_n       asynchronous active-low reset
//   enable_n    active-low frame enable; din is sampled only while low
//   din         serial request bit
//   dout        serial response bit (registered)
//   dout_valid  high while dout carries a response bit (registered)
// ---------------------------------------------------------------------------
module vdic_serial_alu #(
  parameter int unsigned RSP_DELAY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  localparam logic [7:0] CMD_ADD     = 8'h10;
  localparam logic [7:0] CMD_AND     = 8'h01;
  localparam logic [7:0] ST_PARITY   = 8'h20;
  localparam logic [7:0] ST_OPERAND  = 8'h40;
  localparam logic [7:0] ST_COMMAND  = 8'h80;
  localparam logic [6:0] DLY         = 7'(RSP_DELAY);
  // TX cycle counter value on which the edge after the last response bit falls
  localparam logic [5:0] CNT_LAST    = 6'(RSP_DELAY + 28);

  typedef enum logic [1:0] {
    S_RX,
    S_CALC,
    S_TX
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  sh_q, sh_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [1:0]  nops_q, nops_d;
  logic        perr_q, perr_d;
  logic        operr_q, operr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [29:0] frame_q, frame_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dout_q, dout_d;
  logic        dval_q, dval_d;

  logic [9:0]  word_c;
  logic        word_done;
  logic        tx_emit;
  logic [7:0]  status_c;
  logic [15:0] result_c;
  logic [29:0] frame_c;

  function automatic logic [9:0] mk_word(input logic typ, input logic [7:0] pl);
    return {typ, pl, ^{typ, pl}};
  endfunction

  assign word_c    = {sh_q, din};
  assign word_done = (state_q == S_RX) && !enable_n && (bitcnt_q == 4'd9);
  // TX cycle k (counted from the parity edge) is cnt_q+2; emit for
  // k in [RSP_DELAY, RSP_DELAY+29]
  assign tx_emit   = (({1'b0, cnt_q} + 7'd2) >= DLY) && (cnt_q != CNT_LAST);

  // Result and status, evaluated from the collected transaction context
  always_comb begin
    status_c = '0;
    result_c = '0;
    if (perr_q) begin
      status_c = ST_PARITY;
    end else if (operr_q || (nops_q != 2'd2)) begin
      status_c = ST_OPERAND;
    end else if (cmd_q == CMD_ADD) begin
      result_c = {7'd0, {1'b0, opa_q} + {1'b0, opb_q}};
    end else if (cmd_q == CMD_AND) begin
      result_c = {8'd0, opa_q & opb_q};
    end else begin
      status_c = ST_COMMAND;
    end
  end

  assign frame_c = {mk_word(1'b1, status_c),
                    mk_word(1'b0, result_c[15:8]),
                    mk_word(1'b0, result_c[7:0])};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RX;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RX:    if (word_done && word_c[9]) state_d = S_CALC;
      S_CALC:  state_d = S_TX;
      S_TX:    if (cnt_q == CNT_LAST) state_d = S_RX;
      default: state_d = S_RX;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    dout_d = 1'b0;
    dval_d = 1'b0;
    unique case (state_q)
      S_CALC: begin
        // with the minimum delay the first bit leaves on the CALC->TX edge
        if (DLY == 7'd1) begin
          dout_d = frame_c[29];
          dval_d = 1'b1;
        end
      end
      S_TX: begin
        if (tx_emit) begin
          dout_d = frame_q[29];
          dval_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    nops_d   = nops_q;
    perr_d   = perr_q;
    operr_d  = operr_q;
    cmd_d    = cmd_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_RX: begin
        cnt_d = '0;
        if (enable_n) begin
          // partial word dropped; closed operands stay
          bitcnt_d = '0;
        end else begin
          sh_d = word_c[8:0];
          if (bitcnt_q == 4'd9) begin
            bitcnt_d = '0;
            if (^word_c) perr_d = 1'b1;
            if (word_c[9]) begin
              cmd_d = word_c[8:1];
            end else if (nops_q == 2'd0) begin
              opa_d  = word_c[8:1];
              nops_d = 2'd1;
            end else if (nops_q == 2'd1) begin
              opb_d  = word_c[8:1];
              nops_d = 2'd2;
            end else begin
              operr_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      S_CALC: begin
        // context is consumed here and inputs are ignored through TX, so
        // clearing now leaves RX clean when TX ends
        nops_d   = '0;
        perr_d   = 1'b0;
        operr_d  = 1'b0;
        bitcnt_d = '0;
        cnt_d    = '0;
        frame_d  = (DLY == 7'd1) ? {frame_c[28:0], 1'b0} : frame_c;
      end
      S_TX: begin
        cnt_d = cnt_q + 6'd1;
        if (tx_emit) frame_d = {frame_q[28:0], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= '0;
      bitcnt_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      nops_q   <= '0;
      perr_q   <= 1'b0;
      operr_q  <= 1'b0;
      cmd_q    <= '0;
      frame_q  <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dval_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      nops_q   <= nops_d;
      perr_q   <= perr_d;
      operr_q  <= operr_d;
      cmd_q    <= cmd_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;

endmodule

// File: tb/tb_vdic_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_vdic_serial_alu
//   Scoreboard bench: each transaction pushes its expected 30-bit response
//   and first-bit cycle; a negedge monitor reassembles dout and compares.
// ---------------------------------------------------------------------------
module tb_vdic_serial_alu;

  localparam int unsigned DLY = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_n = 1'b1;
  logic din = 1'b0;
  logic dout;
  logic dout_valid;

  vdic_serial_alu #(.RSP_DELAY(DLY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [29:0] frame;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk(input logic typ, input logic [7:0] pl);
    return {typ, pl, ^{typ, pl}};
  endfunction

  // ---------------- monitor ----------------
  int          mon_n = 0;
  int          mon_start = 0;
  logic [29:0] mon_sh = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_n = 0;
    end else if (dout_valid) begin
      if (mon_n == 0) begin
        mon_start = cyc;
        chk("pending_exp", 32'(exp_q.size() != 0), 32'd1);
      end
      mon_sh = {mon_sh[28:0], dout};
      mon_n++;
      if (mon_n == 30) begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("status_word", 32'(mon_sh[29:20]), 32'(mon_e.frame[29:20]));
          chk("res_hi_word", 32'(mon_sh[19:10]), 32'(mon_e.frame[19:10]));
          chk("res_lo_word", 32'(mon_sh[9:0]),   32'(mon_e.frame[9:0]));
          chk("first_bit_cycle", 32'(mon_start), 32'(mon_e.start));
        end
        mon_n = 0;
      end
    end else begin
      if (mon_n != 0) begin
        chk("valid_gap_bits", 32'(mon_n), 32'd0);
        mon_n = 0;
      end
      chk("idle_dout", 32'(dout), 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) begin
      din      = w[i];
      enable_n = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // called right after the CONTROL parity edge
  task automatic push_exp(input logic [29:0] f);
    exp_t e;
    e.frame = f;
    e.start = cyc + int'(DLY);
    exp_q.push_back(e);
  endtask

  task automatic xact(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] cmd, input logic [29:0] f);
    send_word(mk(1'b0, a));
    send_word(mk(1'b0, b));
    send_word(mk(1'b1, cmd));
    push_exp(f);
    enable_n = 1'b1;
    din      = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && mon_n == 0 && !dout_valid) return;
      @(posedge clk);
      #1;
    end
    chk("resp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  exp_t junk;
  int   vcnt;
  logic saw;
  logic fell;

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // arithmetic and logic patterns
    xact(8'h05, 8'h03, 8'h10, {10'h201, 10'h000, 10'h011}); wait_done();
    xact(8'hFF, 8'hFF, 8'h10, {10'h201, 10'h003, 10'h1FD}); wait_done();
    xact(8'h80, 8'h80, 8'h10, {10'h201, 10'h003, 10'h000}); wait_done();
    xact(8'hF0, 8'h3C, 8'h01, {10'h201, 10'h000, 10'h060}); wait_done();
    xact(8'h05, 8'h03, 8'h02, {10'h300, 10'h000, 10'h000}); wait_done();

    // corrupted parity on first DATA
    send_word(mk(1'b0, 8'h05) ^ 10'h001);
    send_word(mk(1'b0, 8'h03));
    send_word(mk(1'b1, 8'h10));
    push_exp({10'h240, 10'h000, 10'h000});
    idle(1); wait_done();

    // CONTROL after a single DATA word
    send_word(mk(1'b0, 8'h05));
    idle(2);
    send_word(mk(1'b1, 8'h10));
    push_exp({10'h280, 10'h000, 10'h000});
    idle(1); wait_done();

    // third DATA word before CONTROL
    send_word(mk(1'b0, 8'h05));
    send_word(mk(1'b0, 8'h03));
    send_word(mk(1'b0, 8'h07));
    send_word(mk(1'b1, 8'h10));
    push_exp({10'h280, 10'h000, 10'h000});
    idle(1); wait_done();

    // bad parity on the CONTROL word itself
    send_word(mk(1'b0, 8'h05));
    send_word(mk(1'b0, 8'h03));
    send_word(mk(1'b1, 8'h10) ^ 10'h001);
    push_exp({10'h240, 10'h000, 10'h000});
    idle(1); wait_done();

    // partial word aborted between operands; operand A survives
    send_word(mk(1'b0, 8'h05));
    for (int i = 0; i < 4; i++) begin
      din = 1'b1; enable_n = 1'b0;
      @(posedge clk); #1;
    end
    idle(2);
    send_word(mk(1'b0, 8'h03));
    send_word(mk(1'b1, 8'h10));
    push_exp({10'h201, 10'h000, 10'h011});
    idle(1); wait_done();

    // enable_n held low through CALC/TX with noise, next request right after
    send_word(mk(1'b0, 8'hFF));
    send_word(mk(1'b0, 8'hFF));
    send_word(mk(1'b1, 8'h10));
    push_exp({10'h201, 10'h003, 10'h1FD});
    saw  = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 100; i++) begin
      din      = 1'($urandom_range(0, 1));
      enable_n = 1'b0;
      @(posedge clk); #1;
      if (dout_valid) saw = 1'b1;
      else if (saw) begin
        fell = 1'b1;
        break;
      end
    end
    chk("b2b_tx_ended", 32'(fell), 32'd1);
    xact(8'hF0, 8'h3C, 8'h01, {10'h201, 10'h000, 10'h060});
    wait_done();

    // reset during the 12th TX cycle
    xact(8'h05, 8'h03, 8'h10, {10'h201, 10'h000, 10'h011});
    vcnt = 0;
    for (int i = 0; i < 100 && vcnt < 12; i++) begin
      @(posedge clk); #1;
      if (dout_valid) vcnt++;
    end
    chk("midtx_reached", 32'(vcnt), 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midtx_rst_dout", 32'(dout), 32'd0);
    chk("midtx_rst_valid", 32'(dout_valid), 32'd0);
    if (exp_q.size() != 0) junk = exp_q.pop_front();
    repeat (2) @(posedge clk);
    #1;
    chk("midtx_hold_valid", 32'(dout_valid), 32'd0);
    rst_n = 1'b1;
    xact(8'h05, 8'h03, 8'h10, {10'h201, 10'h000, 10'h011});
    wait_done();

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
